// File: rtl/apb2axi_txn_sched.sv
// Round-robin issue scheduler: picks a pending directory tag under per-direction
// outstanding limits and presents it on a valid/ready port to the AXI engines.
module apb2axi_txn_sched #(
   parameter int unsigned TAG_NUM      = 16,
   parameter int unsigned TAG_W        = 4,
   parameter int unsigned MAX_OUTST_RD = 8,
   parameter int unsigned MAX_OUTST_WR = 8,
   parameter int unsigned CNT_W        = 5
) (
   input  logic               pclk,
   input  logic               preset,
   input  logic               sched_en,
   input  logic [TAG_NUM-1:0] pend_vld,
   input  logic [TAG_NUM-1:0] pend_is_write,
   output logic               issue_vld,
   output logic [TAG_W-1:0]   issue_tag,
   output logic               issue_is_write,
   input  logic               issue_rdy,
   input  logic               rd_done,
   input  logic               wr_done,
   output logic [CNT_W-1:0]   rd_outst,
   output logic [CNT_W-1:0]   wr_outst,
   output logic               busy,
   output logic               err_underflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1
   } state_t;

   state_t             state;
   logic [TAG_W-1:0]   rr_ptr;
   logic [TAG_W-1:0]   mask_tag;
   logic               mask_vld;

   logic               rd_full;
   logic               wr_full;
   logic [TAG_NUM-1:0] elig;
   logic [TAG_W-1:0]   sel;
   logic               sel_found;
   int unsigned        scan_idx;

   logic               handshake;
   logic               rd_inc;
   logic               wr_inc;
   logic [CNT_W-1:0]   rd_next;
   logic [CNT_W-1:0]   wr_next;
   logic               rd_uf;
   logic               wr_uf;
   logic [TAG_W-1:0]   ptr_next;

   assign rd_full   = (rd_outst == CNT_W'(MAX_OUTST_RD));
   assign wr_full   = (wr_outst == CNT_W'(MAX_OUTST_WR));
   assign handshake = (state == ISSUE) && issue_rdy;
   assign rd_inc    = handshake && !issue_is_write;
   assign wr_inc    = handshake && issue_is_write;
   assign ptr_next  = (issue_tag == TAG_W'(TAG_NUM - 1)) ? '0 : issue_tag + TAG_W'(1);
   assign busy      = issue_vld | (|rd_outst) | (|wr_outst);

   // The just-issued tag is masked for one cycle while the directory clears its pend bit.
   always_comb begin
      elig = '0;
      for (int i = 0; i < TAG_NUM; i++) begin
         elig[i] = pend_vld[i]
                 && !(mask_vld && (mask_tag == TAG_W'(i)))
                 && !(pend_is_write[i] ? wr_full : rd_full);
      end
   end

   // First eligible tag at or after rr_ptr, wrapping at TAG_NUM.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      scan_idx  = 0;
      for (int unsigned k = 0; k < TAG_NUM; k++) begin
         scan_idx = 32'(rr_ptr) + k;
         if (scan_idx >= TAG_NUM) scan_idx = scan_idx - TAG_NUM;
         if (!sel_found && elig[TAG_W'(scan_idx)]) begin
            sel_found = 1'b1;
            sel       = TAG_W'(scan_idx);
         end
      end
   end

   // Outstanding counters: increment on handshake, decrement on done, saturate at 0.
   always_comb begin
      rd_next = rd_outst;
      wr_next = wr_outst;
      rd_uf   = 1'b0;
      wr_uf   = 1'b0;
      if (rd_inc && !rd_done) begin
         rd_next = rd_outst + CNT_W'(1);
      end else if (!rd_inc && rd_done) begin
         if (rd_outst == '0) rd_uf = 1'b1;
         else                rd_next = rd_outst - CNT_W'(1);
      end
      if (wr_inc && !wr_done) begin
         wr_next = wr_outst + CNT_W'(1);
      end else if (!wr_inc && wr_done) begin
         if (wr_outst == '0) wr_uf = 1'b1;
         else                wr_next = wr_outst - CNT_W'(1);
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         mask_tag       <= '0;
         mask_vld       <= 1'b0;
         issue_vld      <= 1'b0;
         issue_tag      <= '0;
         issue_is_write <= 1'b0;
         rd_outst       <= '0;
         wr_outst       <= '0;
         err_underflow  <= 1'b0;
      end else begin
         mask_vld      <= 1'b0;
         rd_outst      <= rd_next;
         wr_outst      <= wr_next;
         err_underflow <= err_underflow | rd_uf | wr_uf;
         case (state)
            IDLE: begin
               if (sched_en && sel_found) begin
                  issue_vld      <= 1'b1;
                  issue_tag      <= sel;
                  issue_is_write <= pend_is_write[sel];
                  state          <= ISSUE;
               end else begin
                  issue_vld <= 1'b0;
               end
            end
            ISSUE: begin
               // Valid is held regardless of sched_en/pend_vld until accepted.
               if (issue_rdy) begin
                  issue_vld <= 1'b0;
                  rr_ptr    <= ptr_next;
                  mask_tag  <= issue_tag;
                  mask_vld  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               issue_vld <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb2axi_txn_sched.sv
// Directed bench for apb2axi_txn_sched, DUT built with a read limit of 2.
module tb_apb2axi_txn_sched;

   logic        pclk;
   logic        preset;
   logic        sched_en;
   logic [15:0] pend_vld;
   logic [15:0] pend_is_write;
   logic        issue_vld;
   logic [3:0]  issue_tag;
   logic        issue_is_write;
   logic        issue_rdy;
   logic        rd_done;
   logic        wr_done;
   logic [4:0]  rd_outst;
   logic [4:0]  wr_outst;
   logic        busy;
   logic        err_underflow;

   int n_cmp = 0;
   int n_bad = 0;

   apb2axi_txn_sched #(
      .TAG_NUM(16), .TAG_W(4), .MAX_OUTST_RD(2), .MAX_OUTST_WR(8), .CNT_W(5)
   ) dut (
      .pclk(pclk), .preset(preset), .sched_en(sched_en),
      .pend_vld(pend_vld), .pend_is_write(pend_is_write),
      .issue_vld(issue_vld), .issue_tag(issue_tag), .issue_is_write(issue_is_write),
      .issue_rdy(issue_rdy), .rd_done(rd_done), .wr_done(wr_done),
      .rd_outst(rd_outst), .wr_outst(wr_outst), .busy(busy),
      .err_underflow(err_underflow)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] pend;
      logic [15:0] isw;
      logic        rdy;
      logic        rdn;
      logic        wdn;
      logic        vld;
      logic [3:0]  tag;
      logic        wr;
      logic [4:0]  rd;
      logic [4:0]  wo;
      logic        bsy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic en, input logic [15:0] pend,
                               input logic [15:0] isw, input logic rdy, input logic rdn,
                               input logic wdn, input logic vld, input logic [3:0] tag,
                               input logic wr, input logic [4:0] rd, input logic [4:0] wo,
                               input logic bsy);
      vec_t v;
      v.rst = rst; v.en = en; v.pend = pend; v.isw = isw; v.rdy = rdy;
      v.rdn = rdn; v.wdn = wdn; v.vld = vld; v.tag = tag; v.wr = wr;
      v.rd = rd; v.wo = wo; v.bsy = bsy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [15:0] pend, input logic [15:0] isw,
                        input logic rdy, input logic rdn, input logic wdn);
      sched_en = en; pend_vld = pend; pend_is_write = isw;
      issue_rdy = rdy; rd_done = rdn; wr_done = wdn;
   endtask

   initial begin
      preset = 1'b1;
      drive(0, 16'h0, 16'h0, 0, 0, 0);

      // rst en pend isw rdy rdn wdn | vld tag wr rd wo busy
      // basic single read
      vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 0, 0,0,0,0,0));
      vecs.push_back(mk(0,1,16'h0001,16'h0000,1,0,0, 1, 0,0,0,0,1));
      vecs.push_back(mk(0,1,16'h0001,16'h0000,1,0,0, 0, 0,0,1,0,1));
      vecs.push_back(mk(0,1,16'h0001,16'h0000,1,0,0, 0, 0,0,1,0,1));
      vecs.push_back(mk(0,1,16'h0000,16'h0000,1,1,0, 0, 0,0,0,0,0));
      // round robin 0,2,15 then 0,2
      vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 0, 0,0,0,0,0));
      vecs.push_back(mk(0,1,16'h8005,16'h8000,1,0,0, 1, 0,0,0,0,1));
      vecs.push_back(mk(0,1,16'h8005,16'h8000,1,0,0, 0, 0,0,1,0,1));
      vecs.push_back(mk(0,1,16'h8005,16'h8000,1,0,0, 1, 2,0,1,0,1));
      vecs.push_back(mk(0,1,16'h8004,16'h8000,1,0,0, 0, 0,0,2,0,1));
      vecs.push_back(mk(0,1,16'h8004,16'h8000,1,0,0, 1,15,1,2,0,1));
      vecs.push_back(mk(0,1,16'h8000,16'h8000,1,0,0, 0, 0,0,2,1,1));
      vecs.push_back(mk(0,1,16'h8000,16'h8000,1,1,0, 0, 0,0,1,1,1));
      vecs.push_back(mk(0,1,16'h0005,16'h0000,1,1,0, 1, 0,0,0,1,1));
      vecs.push_back(mk(0,1,16'h0005,16'h0000,1,0,0, 0, 0,0,1,1,1));
      vecs.push_back(mk(0,1,16'h0005,16'h0000,1,0,0, 1, 2,0,1,1,1));
      vecs.push_back(mk(0,1,16'h0004,16'h0000,1,0,0, 0, 0,0,2,1,1));
      vecs.push_back(mk(0,1,16'h0004,16'h0000,1,0,0, 0, 0,0,2,1,1));
      vecs.push_back(mk(0,1,16'h0000,16'h0000,1,1,0, 0, 0,0,1,1,1));
      vecs.push_back(mk(0,1,16'h0000,16'h0000,1,1,1, 0, 0,0,0,0,0));
      // read limit 2: reads 1,2 then write 9, reads 4,5 wait for rd_done
      vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 0, 0,0,0,0,0));
      vecs.push_back(mk(0,1,16'h0236,16'h0200,1,0,0, 1, 1,0,0,0,1));
      vecs.push_back(mk(0,1,16'h0236,16'h0200,1,0,0, 0, 0,0,1,0,1));
      vecs.push_back(mk(0,1,16'h0236,16'h0200,1,0,0, 1, 2,0,1,0,1));
      vecs.push_back(mk(0,1,16'h0234,16'h0200,1,0,0, 0, 0,0,2,0,1));
      vecs.push_back(mk(0,1,16'h0234,16'h0200,1,0,0, 1, 9,1,2,0,1));
      vecs.push_back(mk(0,1,16'h0230,16'h0200,1,0,0, 0, 0,0,2,1,1));
      vecs.push_back(mk(0,1,16'h0230,16'h0200,1,0,0, 0, 0,0,2,1,1));
      vecs.push_back(mk(0,1,16'h0030,16'h0000,1,0,0, 0, 0,0,2,1,1));
      vecs.push_back(mk(0,1,16'h0030,16'h0000,1,1,0, 0, 0,0,1,1,1));
      vecs.push_back(mk(0,1,16'h0030,16'h0000,1,0,0, 1, 4,0,1,1,1));
      vecs.push_back(mk(0,1,16'h0020,16'h0000,1,0,0, 0, 0,0,2,1,1));
      vecs.push_back(mk(0,1,16'h0020,16'h0000,1,0,0, 0, 0,0,2,1,1));

      for (int i = 0; i < vecs.size(); i++) begin
         preset = vecs[i].rst;
         drive(vecs[i].en, vecs[i].pend, vecs[i].isw, vecs[i].rdy, vecs[i].rdn, vecs[i].wdn);
         cyc();
         chk($sformatf("v%0d issue_vld", i), 32'(issue_vld), 32'(vecs[i].vld));
         if (vecs[i].vld) begin
            chk($sformatf("v%0d issue_tag", i), 32'(issue_tag), 32'(vecs[i].tag));
            chk($sformatf("v%0d issue_is_write", i), 32'(issue_is_write), 32'(vecs[i].wr));
         end
         chk($sformatf("v%0d rd_outst", i), 32'(rd_outst), 32'(vecs[i].rd));
         chk($sformatf("v%0d wr_outst", i), 32'(wr_outst), 32'(vecs[i].wo));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
         chk($sformatf("v%0d err_underflow", i), 32'(err_underflow), 32'h0);
      end

      // backpressure: tag 3 write held 5 cycles while sched_en and pend drop
      preset = 1'b1;
      drive(0, 16'h0, 16'h0, 0, 0, 0);
      cyc();
      preset = 1'b0;
      drive(1, 16'h0008, 16'h0008, 0, 0, 0);
      cyc();
      chk("bp first vld", 32'(issue_vld), 32'h1);
      chk("bp first tag", 32'(issue_tag), 32'h3);
      drive(0, 16'h0, 16'h0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("bp hold%0d vld", k), 32'(issue_vld), 32'h1);
         chk($sformatf("bp hold%0d tag", k), 32'(issue_tag), 32'h3);
         chk($sformatf("bp hold%0d is_write", k), 32'(issue_is_write), 32'h1);
         chk($sformatf("bp hold%0d wr_outst", k), 32'(wr_outst), 32'h0);
      end
      issue_rdy = 1'b1;
      cyc();
      chk("bp done vld", 32'(issue_vld), 32'h0);
      chk("bp done wr_outst", 32'(wr_outst), 32'h1);

      // handshake coinciding with rd_done, then write underflow
      drive(1, 16'h0040, 16'h0, 1, 0, 0);
      cyc();
      chk("sim tag6", 32'(issue_tag), 32'h6);
      cyc();
      chk("sim rd_outst1", 32'(rd_outst), 32'h1);
      drive(1, 16'h0080, 16'h0, 1, 0, 0);
      cyc();
      chk("sim tag7 vld", 32'(issue_vld), 32'h1);
      chk("sim tag7", 32'(issue_tag), 32'h7);
      rd_done = 1'b1;
      cyc();
      chk("sim hs+done vld", 32'(issue_vld), 32'h0);
      chk("sim hs+done rd_outst", 32'(rd_outst), 32'h1);
      drive(1, 16'h0, 16'h0, 1, 0, 1);
      cyc();
      chk("uf wr dec", 32'(wr_outst), 32'h0);
      chk("uf not yet", 32'(err_underflow), 32'h0);
      cyc();
      chk("uf wr stays 0", 32'(wr_outst), 32'h0);
      chk("uf set", 32'(err_underflow), 32'h1);
      wr_done = 1'b0;
      cyc();
      chk("uf sticky", 32'(err_underflow), 32'h1);
      chk("uf busy", 32'(busy), 32'h1);

      // asynchronous reset while holding an issue with reads at the limit
      drive(1, 16'h0100, 16'h0, 1, 0, 0);
      cyc();
      chk("ar tag8", 32'(issue_tag), 32'h8);
      cyc();
      chk("ar rd_outst2", 32'(rd_outst), 32'h2);
      drive(1, 16'h0400, 16'h0400, 0, 0, 0);
      cyc();
      chk("ar pre vld", 32'(issue_vld), 32'h1);
      chk("ar pre tag", 32'(issue_tag), 32'ha);
      #3;
      preset = 1'b1;
      #1;
      chk("ar vld", 32'(issue_vld), 32'h0);
      chk("ar tag", 32'(issue_tag), 32'h0);
      chk("ar is_write", 32'(issue_is_write), 32'h0);
      chk("ar rd_outst", 32'(rd_outst), 32'h0);
      chk("ar wr_outst", 32'(wr_outst), 32'h0);
      chk("ar busy", 32'(busy), 32'h0);
      chk("ar err", 32'(err_underflow), 32'h0);
      cyc();
      chk("ar held vld", 32'(issue_vld), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
